// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master: transmit FSM encoding, word size and
// the bit-counter masks that mark the last beat of a FIFO word.
package spi_master_pkg;

  localparam int unsigned SPI_WORD_BITS = 32;

  // Low bits of the beat counter that are all-ones on the final beat of a word
  localparam logic [4:0] StdWordMask  = 5'h1f;
  localparam logic [4:0] QuadWordMask = 5'h07;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StTransmit = 2'd1,
    StStall    = 2'd2
  } state_e;

  function automatic logic word_boundary(input logic [4:0] cnt_lo, input logic quad);
    logic [4:0] mask;
    mask = quad ? QuadWordMask : StdWordMask;
    return (cnt_lo & mask) == mask;
  endfunction

endpackage

// File: rtl/spi_master_tx.sv
// SPI transmit shifter: drains 32-bit FIFO words onto sdo0..3, MSB first.
// Quad mode (en_quad_i) exists only when SPI_MASTER_QUAD_EN is defined.
module spi_master_tx
  import spi_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_WORD_BITS,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  en_i,
`ifdef SPI_MASTER_QUAD_EN
  input  logic                  en_quad_i,
`endif
  input  logic                  tx_edge_i,
  input  logic [CNT_WIDTH-1:0]  counter_in_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  output logic                  sdo0_o,
  output logic                  sdo1_o,
  output logic                  sdo2_o,
  output logic                  sdo3_o,
  output logic                  clk_en_o,
  output logic                  tx_done_o
);

  state_e                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_WIDTH-1:0]  bit_cnt_q;
  logic [CNT_WIDTH-1:0]  target_q;
  logic                  quad_q;
  logic                  clk_en_q;
  logic                  tx_done_q;

  logic                  quad_start;
  logic [CNT_WIDTH-1:0]  beats;
  logic                  start_ok;
  logic                  zero_len;
  logic                  start;
  logic                  at_last;
  logic                  boundary;
  logic                  reload;

`ifdef SPI_MASTER_QUAD_EN
  assign quad_start = en_quad_i;
`else
  assign quad_start = 1'b0;
`endif

  always_comb begin
    beats    = quad_start ? (counter_in_i >> 2) : counter_in_i;
    // Holding off a start while tx_done is high keeps done and ready disjoint
    start_ok = (state_q == StIdle) && en_i && !tx_done_q && !clr_i;
    zero_len = start_ok && (beats == '0);
    start    = start_ok && (beats != '0) && data_valid_i;
    at_last  = (bit_cnt_q == target_q);
    boundary = word_boundary(bit_cnt_q[4:0], quad_q);
    reload   = !clr_i && data_valid_i &&
               (((state_q == StTransmit) && tx_edge_i && !at_last && boundary) ||
                (state_q == StStall));
    data_ready_o = rst_ni && (start || reload);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      target_q  <= '0;
      quad_q    <= 1'b0;
      clk_en_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (clr_i) begin
        state_q   <= StIdle;
        shift_q   <= '0;
        bit_cnt_q <= '0;
        clk_en_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (zero_len) begin
              tx_done_q <= 1'b1;
            end else if (start) begin
              shift_q   <= data_i;
              bit_cnt_q <= '0;
              target_q  <= beats - CNT_WIDTH'(1);
              quad_q    <= quad_start;
              clk_en_q  <= 1'b1;
              state_q   <= StTransmit;
            end
          end
          StTransmit: begin
            if (tx_edge_i) begin
              if (at_last) begin
                // Unsent remainder of the current word is dropped
                tx_done_q <= 1'b1;
                clk_en_q  <= 1'b0;
                shift_q   <= '0;
                state_q   <= StIdle;
              end else if (boundary) begin
                if (data_valid_i) begin
                  shift_q   <= data_i;
                  bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
                end else begin
                  clk_en_q <= 1'b0;
                  state_q  <= StStall;
                end
              end else begin
                shift_q   <= quad_q ? (shift_q << 4) : (shift_q << 1);
                bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
              end
            end
          end
          StStall: begin
            if (data_valid_i) begin
              shift_q   <= data_i;
              bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
              clk_en_q  <= 1'b1;
              state_q   <= StTransmit;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign clk_en_o  = clk_en_q;
  assign tx_done_o = tx_done_q;
  assign sdo0_o    = quad_q ? shift_q[DATA_WIDTH-4] : shift_q[DATA_WIDTH-1];
  assign sdo1_o    = quad_q & shift_q[DATA_WIDTH-3];
  assign sdo2_o    = quad_q & shift_q[DATA_WIDTH-2];
  assign sdo3_o    = quad_q & shift_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: table of std transfers plus hand-written
// zero-length, abort, reset and (with SPI_MASTER_QUAD_EN) quad sequences.
module tb_spi_master_tx;

  logic        clk = 1'b0;
  logic        rst_n, clr, en, tx_edge, data_valid, data_ready;
  logic        sdo0, sdo1, sdo2, sdo3, clk_en, tx_done;
  logic [15:0] counter_in;
  logic [31:0] data;
`ifdef SPI_MASTER_QUAD_EN
  logic        en_quad;
`endif

  always #5 clk = ~clk;

  spi_master_tx dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .en_i        (en),
`ifdef SPI_MASTER_QUAD_EN
    .en_quad_i   (en_quad),
`endif
    .tx_edge_i   (tx_edge),
    .counter_in_i(counter_in),
    .data_i      (data),
    .data_valid_i(data_valid),
    .data_ready_o(data_ready),
    .sdo0_o      (sdo0),
    .sdo1_o      (sdo1),
    .sdo2_o      (sdo2),
    .sdo3_o      (sdo3),
    .clk_en_o    (clk_en),
    .tx_done_o   (tx_done)
  );

  typedef struct {
    string       name;
    int          nbits;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          gap;        // edges only every other cycle
    int          delay;      // stall cycles before the second word is queued
    int          exp_ready;
    int          exp_stall;  // cycles with clk_en low between start and done
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] fifo[$];
  int          checks = 0;
  int          errors = 0;
  int          n_ready, n_done;
  logic        s_ready, s_done, s_clk_en, s_valid;
  logic        prev_ready = 1'b0;
  logic [3:0]  s_sdo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    data_valid = (fifo.size() != 0);
    data       = (fifo.size() != 0) ? fifo[0] : 32'h0;
  endtask

  // One clock: sample outputs at negedge, retire a consumed word after posedge
  task automatic step();
    drive_fifo();
    @(negedge clk);
    s_ready  = data_ready;
    s_done   = tx_done;
    s_clk_en = clk_en;
    s_valid  = data_valid;
    s_sdo    = {sdo3, sdo2, sdo1, sdo0};
    if (s_ready) begin
      n_ready++;
      check("ready_needs_valid", 32'(s_valid), 32'd1);
      check("ready_vs_done", 32'(s_done), 32'd0);
      check("ready_back_to_back", 32'(prev_ready), 32'd0);
    end
    if (s_done) n_done++;
    prev_ready = s_ready;
    @(posedge clk);
    #1;
    if (s_ready) void'(fifo.pop_front());
    drive_fifo();
  endtask

  function automatic logic exp_bit(input int j, input logic [31:0] w0, input logic [31:0] w1);
    if (j < 32) return w0[31-j];
    return w1[63-j];
  endfunction

  task automatic run_xfer(input vec_t v);
    int   j = 0;
    int   stall = 0;
    int   cyc = 0;
    bit   need_w1, pushed, done_seen;
    logic e;
    need_w1 = (v.nbits > 32);
    pushed  = need_w1 && (v.delay == 0);
    fifo.push_back(v.w0);
    if (pushed) fifo.push_back(v.w1);
    n_ready = 0;
    n_done  = 0;
    en = 1'b1;
    counter_in = 16'(v.nbits);
    step();
    check({v.name, "_start_ready"}, 32'(s_ready), 32'd1);
    check({v.name, "_start_clk_en"}, 32'(s_clk_en), 32'd0);
    en = 1'b0;
    counter_in = 16'h0003;  // must be ignored mid-transfer
    done_seen = 1'b0;
    while (!done_seen && cyc < 400) begin
      e = v.gap ? cyc[0] : 1'b1;
      tx_edge = e;
      step();
      tx_edge = 1'b0;
      cyc++;
      if (s_done) begin
        done_seen = 1'b1;
      end else if (s_clk_en) begin
        if (j < v.nbits) check({v.name, "_sdo0"}, 32'(s_sdo[0]), 32'(exp_bit(j, v.w0, v.w1)));
        if (e) j++;
      end else begin
        stall++;
        if (need_w1 && !pushed && stall == v.delay) begin
          fifo.push_back(v.w1);
          pushed = 1'b1;
        end
      end
    end
    check({v.name, "_done_seen"}, 32'(done_seen), 32'd1);
    check({v.name, "_bits_sent"}, 32'(j), 32'(v.nbits));
    check({v.name, "_ready_count"}, 32'(n_ready), 32'(v.exp_ready));
    check({v.name, "_stall_cycles"}, 32'(stall), 32'(v.exp_stall));
    check({v.name, "_clk_en_at_done"}, 32'(s_clk_en), 32'd0);
    check({v.name, "_sdo123_zero"}, 32'(s_sdo[3:1]), 32'd0);
    step();
    check({v.name, "_done_one_pulse"}, 32'(s_done), 32'd0);
    check({v.name, "_fifo_drained"}, 32'(fifo.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"std8",       8,  32'hA5000000, 32'h0,        1'b0, 0,  1, 0};
    vecs[1] = '{"std64",      64, 32'hDEADBEEF, 32'h12345678, 1'b0, 0,  2, 0};
    vecs[2] = '{"underrun40", 40, 32'hDEADBEEF, 32'h12345678, 1'b0, 10, 2, 11};
    vecs[3] = '{"std1_gap",   1,  32'h80000000, 32'h0,        1'b1, 0,  1, 0};
    vecs[4] = '{"std33_gap",  33, 32'h0F0F0F0F, 32'h80000001, 1'b1, 0,  2, 0};
    vecs[5] = '{"std32",      32, 32'h13579BDF, 32'h0,        1'b0, 0,  1, 0};

    rst_n = 1'b1; clr = 1'b0; en = 1'b0; tx_edge = 1'b0; counter_in = '0;
`ifdef SPI_MASTER_QUAD_EN
    en_quad = 1'b0;
`endif
    drive_fifo();
    #2 rst_n = 1'b0;
    #1;
    check("reset_clk_en", 32'(clk_en), 32'd0);
    check("reset_tx_done", 32'(tx_done), 32'd0);
    check("reset_ready", 32'(data_ready), 32'd0);
    check("reset_sdo", 32'({sdo3, sdo2, sdo1, sdo0}), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // Zero length: word present but untouched, single done pulse
    fifo.push_back(32'hCAFEF00D);
    en = 1'b1;
    counter_in = 16'd0;
    step();
    check("zl_no_ready", 32'(s_ready), 32'd0);
    en = 1'b0;
    step();
    check("zl_done", 32'(s_done), 32'd1);
    check("zl_clk_en", 32'(s_clk_en), 32'd0);
    step();
    check("zl_done_once", 32'(s_done), 32'd0);
    check("zl_word_kept", 32'(fifo.size()), 32'd1);
    fifo.delete();

    // Abort after five edges of a 32-bit transfer
    fifo.push_back(32'hFFFFFFFF);
    en = 1'b1;
    counter_in = 16'd32;
    step();
    en = 1'b0;
    n_done = 0;
    for (int i = 0; i < 5; i++) begin
      tx_edge = 1'b1;
      step();
    end
    clr = 1'b1;
    step();
    check("clr_no_ready", 32'(s_ready), 32'd0);
    check("clr_cycle_sdo", 32'(s_sdo[0]), 32'd1);
    clr = 1'b0;
    step();
    check("clr_idle_clk_en", 32'(s_clk_en), 32'd0);
    check("clr_sdo_cleared", 32'(s_sdo), 32'd0);
    for (int i = 0; i < 3; i++) step();
    tx_edge = 1'b0;
    check("clr_no_done", 32'(n_done), 32'd0);
    run_xfer(vecs[0]);

    // Asynchronous reset mid-transfer
    fifo.push_back(32'hFFFFFFFF);
    en = 1'b1;
    counter_in = 16'd32;
    step();
    for (int i = 0; i < 3; i++) begin
      tx_edge = 1'b1;
      step();
    end
    fifo.push_back(32'hFFFFFFFF);
    drive_fifo();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_clk_en", 32'(clk_en), 32'd0);
    check("rst_mid_sdo", 32'({sdo3, sdo2, sdo1, sdo0}), 32'd0);
    check("rst_mid_ready", 32'(data_ready), 32'd0);
    check("rst_mid_done", 32'(tx_done), 32'd0);
    en = 1'b0;
    tx_edge = 1'b0;
    fifo.delete();
    drive_fifo();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    check("rst_after_clk_en", 32'(s_clk_en), 32'd0);

`ifdef SPI_MASTER_QUAD_EN
    begin
      logic [31:0] qw;
      qw = 32'hF0C3A581;
      fifo.push_back(qw);
      en_quad = 1'b1;
      en = 1'b1;
      counter_in = 16'd32;
      step();
      check("quad_start_ready", 32'(s_ready), 32'd1);
      en = 1'b0;
      en_quad = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tx_edge = 1'b1;
        step();
        check("quad_nibble", 32'(s_sdo), 32'(qw[31-4*i -: 4]));
      end
      step();
      tx_edge = 1'b0;
      check("quad_done", 32'(s_done), 32'd1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
